// File: rtl/uart_pkg.sv
// Shared encodings and oversampling constants for the 8N1 serial receiver.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int OVERSAMPLE = 16;
  localparam int MID        = OVERSAMPLE / 2 - 1;

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchroniser for the raw rx line plus a one-clk tick on each
// rising edge of the prescaler's 16x strobe.
module rx_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic uart_clk,
  output logic rx_sync,
  output logic tick
);

  logic rx_meta;
  logic uart_clk_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      uart_clk_d <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      uart_clk_d <= uart_clk;
    end
  end

  assign tick = uart_clk & ~uart_clk_d;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first receiver timed by a 16x tick; presents bytes on valid/ready
// and flags framing errors (pulse) and overruns (sticky).
//   state | meaning
//   IDLE  | waiting for a low sample on a tick
//   START | qualifying the start bit until its middle
//   DATA  | sampling payload bits at mid-bit
//   STOP  | sampling the stop bit, then back to IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  logic                 rx_sync;
  logic                 tick;
  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [3:0]           cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 cnt_mid;
  logic                 cnt_last;
  logic                 last_bit;
  logic                 sample_bit;
  logic                 stop_ok;
  logic                 stop_bad;

  rx_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .uart_clk (uart_clk),
    .rx_sync  (rx_sync),
    .tick     (tick)
  );

  assign cnt_mid  = (cnt == 4'(MID));
  assign cnt_last = (cnt == 4'(OVERSAMPLE - 1));
  assign last_bit = (bit_idx == 3'(DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick && !rx_sync) state_nxt = START;
      START:   if (tick && cnt_mid) state_nxt = rx_sync ? IDLE : DATA;
      DATA:    if (tick && cnt_last && last_bit) state_nxt = STOP;
      STOP:    if (tick && cnt_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    sample_bit = tick && cnt_last && (state == DATA);
    stop_ok    = tick && cnt_last && (state == STOP) && rx_sync;
    stop_bad   = tick && cnt_last && (state == STOP) && !rx_sync;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      // Any state change restarts the tick count; inside DATA it wraps 15->0.
      if (tick) cnt <= (state_nxt != state) ? 4'd0 : cnt + 4'd1;
      if (state == START) bit_idx <= '0;
      else if (sample_bit && !last_bit) bit_idx <= bit_idx + 3'd1;
      if (sample_bit) shift <= {rx_sync, shift[DATA_BITS-1:1]};
      if (stop_ok) begin
        data  <= shift;
        valid <= 1'b1;
        if (valid && !ready) overrun <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 13-clk prescaler strobe, 208-clk bit period.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_CLK = 13 * 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_clk = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int         n_valid = 0;
  int         n_valid_cyc = 0;
  int         n_ferr = 0;
  logic       busy_seen = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b1;
  logic [7:0] rx_q[$];

  uart_rx #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_clk  (uart_clk),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin : presc
    int pc;
    pc = 0;
    forever begin
      @(negedge clk);
      pc = (pc == 12) ? 0 : pc + 1;
      uart_clk = (pc < 6);
    end
  end

  // Records each newly presented byte (valid rising, or reloaded after acceptance).
  initial begin : mon
    forever begin
      @(negedge clk);
      if (valid) begin
        n_valid_cyc++;
        if (!prev_valid || prev_ready) begin
          n_valid++;
          rx_q.push_back(data);
        end
      end
      if (frame_err) n_ferr++;
      if (busy) busy_seen = 1'b1;
      prev_valid = valid;
      prev_ready = ready;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    n_valid = 0;
    n_valid_cyc = 0;
    n_ferr = 0;
    busy_seen = 1'b0;
    rx_q.delete();
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  initial begin
    wait_clk(3);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    wait_clk(20);

    // single byte
    clear_mon();
    send_byte(8'hA5, 1'b1);
    wait_clk(100);
    check("a5_count", n_valid, 1);
    check("a5_data", rx_q[0], 8'hA5);
    check("a5_valid_width", n_valid_cyc, 1);
    check("a5_ferr", n_ferr, 0);
    check("a5_overrun", overrun, 1'b0);
    check("a5_busy", busy, 1'b0);

    // back-to-back frames, no idle gap
    clear_mon();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_clk(100);
    check("b2b_count", n_valid, 2);
    check("b2b_first", rx_q[0], 8'h00);
    check("b2b_second", rx_q[1], 8'hFF);
    check("b2b_ferr", n_ferr, 0);

    // short low glitch rejected at mid-start
    clear_mon();
    rx = 1'b0;
    wait_clk(52);
    rx = 1'b1;
    wait_clk(150);
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy", busy, 1'b0);
    check("glitch_valid", n_valid, 0);
    check("glitch_ferr", n_ferr, 0);
    check("glitch_data", data, 8'hFF);

    // framing error
    clear_mon();
    send_byte(8'h3C, 1'b0);
    wait_clk(300);
    check("ferr_pulse_cycles", n_ferr, 1);
    check("ferr_valid", n_valid, 0);
    check("ferr_data", data, 8'hFF);
    check("ferr_busy", busy, 1'b0);

    // overrun with ready low
    clear_mon();
    ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_clk(100);
    check("ovr_valid_held", valid, 1'b1);
    check("ovr_data", data, 8'h22);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_presentations", n_valid, 1);
    ready = 1'b1;
    wait_clk(1);
    check("ovr_valid_drop", valid, 1'b0);
    wait_clk(50);
    check("ovr_sticky", overrun, 1'b1);

    // reset in the middle of data bit 4
    clear_mon();
    fork
      send_byte(8'h5A, 1'b1);
      begin
        wait_clk(BIT_CLK * 5 + 104);
        check("mid_busy", busy, 1'b1);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        check("mrst_busy", busy, 1'b0);
        check("mrst_valid", valid, 1'b0);
        check("mrst_ferr", frame_err, 1'b0);
        check("mrst_overrun", overrun, 1'b0);
      end
    join
    // let any frame resynchronised on the remaining bits run out
    wait_clk(2500);
    clear_mon();
    send_byte(8'h5A, 1'b1);
    wait_clk(100);
    check("post_rst_count", n_valid, 1);
    check("post_rst_data", rx_q[0], 8'h5A);
    check("post_rst_ferr", n_ferr, 0);
    check("post_rst_overrun", overrun, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial byte receiver directly downstream of the clock prescaler.
- Consumes the prescaler's 16x-baud `uart_clk` as a sample strobe and the raw asynchronous `rx` line.
- Recovers 8N1 frames LSB-first and presents bytes on a valid/ready interface to the scan-chain command decoder.
- Flags framing errors and overruns.

Parameters:
- DATA_BITS, 8, payload bits per frame (5..8)
- OVERSAMPLE, 16, uart_clk ticks per bit; must match the prescaler's 16x rate
- MID, OVERSAMPLE/2-1 (=7), tick index of mid-start-bit sample

Ports:
- clk  input  1  system clock (12 MHz)
- reset  input  1  synchronous, active-high reset
- uart_clk  input  1  16x baud square wave from the prescaler, same clk domain; only its rising edge is used
- rx  input  1  asynchronous serial data, idle high
- data  output  DATA_BITS  received byte, valid while valid=1
- valid  output  1  byte available
- ready  input  1  consumer accepts byte when valid&ready
- frame_err  output  1  one-clk pulse: stop bit sampled low
- overrun  output  1  sticky: byte completed while valid still high; cleared by reset only
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous, active-high, and overrides all other inputs. Reset values:
  - state=IDLE; data=0, valid=0, frame_err=0, overrun=0, busy=0
  - rx sync flops=1; uart_clk delay flop=0
  - Reset mid-frame abandons the frame with no flags raised.
- rx passes through two flops (rx_meta, rx_sync) before use; 2-clk latency.
- tick = uart_clk & ~uart_clk_d: one clk wide, once per 16x period (every 13 clk at 57,600 baud). All bit timing advances only on tick.
- Tick counter cnt is 4 bits; bit index is 3 bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on tick with rx_sync=0 → START, cnt=0.
  - START: cnt increments per tick. At cnt==MID:
    - rx_sync=1 → IDLE (glitch rejected, no flags).
    - rx_sync=0 → DATA, cnt=0, bit=0.
  - DATA: cnt increments per tick, wrapping 15→0. At cnt==15 (mid-bit), shift rx_sync into shift[DATA_BITS-1] (right shift, LSB first).
    - If bit==DATA_BITS-1 → STOP, cnt=0; else bit++.
  - STOP: at cnt==15, sample rx_sync, then → IDLE.
    - rx_sync=1: data<=shift, valid<=1.
    - rx_sync=0: frame_err pulses 1 clk; data and valid unchanged.
- Return to IDLE occurs mid-stop-bit, so back-to-back frames resynchronise on the next start edge.
- Handshake:
  - valid falls the clk after valid&ready.
  - If a new byte completes in the same clk as valid&ready, the new byte loads, valid stays 1, and there is no overrun.
  - If a new byte completes while valid=1 and ready=0, the new byte overwrites data, valid stays 1, and overrun sets.
- Latency: valid rises 1 clk after the mid-stop tick.
- data is stable while valid=1, except on overwrite.
- ready while valid=0 is ignored.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3)
  - OVERSAMPLE
  - MID
- One sub-module: rx_sync_edge, containing the 2-flop rx synchroniser plus uart_clk rising-edge tick generator. It outputs rx_sync and tick, and takes reset.

Test Plan:
- Setup for all cases: 12 MHz clk, prescaler-style uart_clk with period 13 clk and ready=1.
- Send 0xA5 as 8N1 at 57,600 baud → valid pulses 1 clk with data=0xA5, frame_err=0, overrun=0, busy low after mid-stop.
- Send 0x00 then 0xFF back-to-back, no idle gap → two valid events with data 0x00 then 0xFF; no frame_err.
- Drive rx low for 4 ticks (52 clk) then high → busy rises then falls by tick 7; valid, frame_err and data unchanged.
- Send 0x3C with stop bit forced low → frame_err 1-clk pulse, valid stays 0, data retains previous value.
- Set ready=0, send 0x11 then 0x22 → valid held, data=0x22, overrun=1. Then raise ready → valid drops next clk; overrun stays 1 until reset.
- Assert reset for 1 clk during DATA bit 4 of 0x5A → busy=0, valid=0, no flags. A following 0x5A frame is received correctly.
